esc_string_decoder: RTL and testbench

//  Receives a byte stream of escaped ASCII text ending in a terminator flag.

---
 rtl/esc_string_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_esc_string_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_string_decoder.sv
// -----------------------------------------------------------------------------
// esc_string_decoder
//
// Purpose:
//   Receives a byte stream of escaped ASCII text, one string per in_last-
//   terminated burst. Decodes \n \t \\ \" and \ooo (three octal digits) and
//   packs the decoded characters into a right-justified string register laid
//   out like a Verilog string literal: the most recent character sits in
//   [7:0] and unused upper bytes are zero. The finished string is held on
//   the output until the sink takes it. Input bytes are not accepted while
//   a finished string is waiting.
//
// Ports:
//   clk        in   1                      rising-edge clock
//   rst        in   1                      asynchronous reset, active-high
//   in_valid   in   1                      in_data/in_last valid
//   in_ready   out  1                      decoder can accept a byte
//   in_data    in   8                      escaped ASCII byte
//   in_last    in   1                      final byte of the string
//   out_valid  out  1                      decoded string available
//   out_ready  in   1                      sink accepts the string
//   out_data   out  8*MAX_CHARS            decoded string, last char in [7:0]
//   out_len    out  $clog2(MAX_CHARS+1)    number of decoded characters
//   out_err    out  1                      sticky error for this string
//
// The reset input is expected to be released synchronously to clk by the
// surrounding reset logic; assertion takes effect immediately.
//
// State table:
//   state | meaning
//   NORM  | plain characters are appended
//   ESC   | escape introducer seen, waiting for the escape code
//   OCT1  | one octal digit collected in acc
//   OCT2  | two octal digits collected in acc
//   DONE  | string complete, presented on out_*, waiting for out_ready
// -----------------------------------------------------------------------------
module esc_string_decoder #(
    parameter int          MAX_CHARS = 14,
    parameter logic [7:0]  ESC_CHAR  = 8'h5C
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [8*MAX_CHARS-1:0]             out_data,
    output logic [$clog2(MAX_CHARS+1)-1:0]     out_len,
    output logic                               out_err
);

    localparam int LW = $clog2(MAX_CHARS + 1);
    localparam int BW = 8 * MAX_CHARS;

    typedef enum logic [2:0] {
        NORM = 3'd0,
        ESC  = 3'd1,
        OCT1 = 3'd2,
        OCT2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   buffer, buffer_nx;
    logic [LW-1:0]   len, len_nx;
    logic            err, err_nx;
    logic [5:0]      acc, acc_nx;

    logic            accept;
    logic            is_digit;
    logic [2:0]      digit;
    logic [8:0]      oct_value;
    logic            append_en;
    logic [7:0]      append_byte;
    logic            set_err;
    state_t          target;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_data  = buffer;
    assign out_len   = len;
    assign out_err   = err;

    assign accept    = in_valid && in_ready;
    assign is_digit  = (in_data >= 8'h30) && (in_data <= 8'h37);
    assign digit     = in_data[2:0];
    // Full three-digit value; bit 8 set means the escape exceeded 0xFF.
    assign oct_value = {acc, 3'b000} + {6'b000000, digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= NORM;
            buffer <= '0;
            len    <= '0;
            err    <= 1'b0;
            acc    <= '0;
        end else begin
            state  <= state_nx;
            buffer <= buffer_nx;
            len    <= len_nx;
            err    <= err_nx;
            acc    <= acc_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        buffer_nx   = buffer;
        len_nx      = len;
        err_nx      = err;
        acc_nx      = acc;
        append_en   = 1'b0;
        append_byte = 8'h00;
        set_err     = 1'b0;
        target      = state;

        if (accept) begin
            case (state)
                NORM: begin
                    if (in_data == ESC_CHAR) begin
                        target = ESC;
                    end else begin
                        append_en   = 1'b1;
                        append_byte = in_data;
                    end
                end
                ESC: begin
                    target = NORM;
                    case (in_data)
                        8'h6E: begin append_en = 1'b1; append_byte = 8'h0A; end
                        8'h74: begin append_en = 1'b1; append_byte = 8'h09; end
                        8'h5C: begin append_en = 1'b1; append_byte = 8'h5C; end
                        8'h22: begin append_en = 1'b1; append_byte = 8'h22; end
                        default: begin
                            if (is_digit) begin
                                acc_nx = {3'b000, digit};
                                target = OCT1;
                            end else begin
                                // Unknown escape: keep the character, flag it.
                                append_en   = 1'b1;
                                append_byte = in_data;
                                set_err     = 1'b1;
                            end
                        end
                    endcase
                end
                OCT1: begin
                    if (is_digit) begin
                        // acc < 8 here, so the shift cannot lose bits.
                        acc_nx = {acc[2:0], digit};
                        target = OCT2;
                    end else begin
                        set_err = 1'b1;
                        acc_nx  = '0;
                        target  = NORM;
                    end
                end
                OCT2: begin
                    acc_nx = '0;
                    target = NORM;
                    if (is_digit) begin
                        append_en   = 1'b1;
                        append_byte = oct_value[7:0];
                        set_err     = oct_value[8];
                    end else begin
                        set_err = 1'b1;
                    end
                end
                default: begin
                    target = state;
                end
            endcase

            if (append_en) begin
                if (len < LW'(MAX_CHARS)) begin
                    buffer_nx = {buffer[BW-9:0], append_byte};
                    len_nx    = len + LW'(1);
                end else begin
                    set_err = 1'b1;
                end
            end

            if (in_last) begin
                // A string ending inside an escape loses the partial escape.
                if (target == ESC || target == OCT1 || target == OCT2) begin
                    set_err = 1'b1;
                    acc_nx  = '0;
                end
                target = DONE;
            end

            err_nx   = err | set_err;
            state_nx = target;
        end else if (state == DONE && out_ready) begin
            buffer_nx = '0;
            len_nx    = '0;
            err_nx    = 1'b0;
            acc_nx    = '0;
            state_nx  = NORM;
        end
    end

endmodule

// File: tb/tb_esc_string_decoder.sv
module tb_esc_string_decoder;

    localparam int MAXC = 14;
    localparam int LW   = $clog2(MAXC + 1);

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int             n;
        logic [159:0]   bytes;   // first byte most significant, right-justified
        logic [111:0]   data;
        int             len;
        bit             err;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [8*MAXC-1:0] out_data;
    logic [LW-1:0]     out_len;
    logic              out_err;

    int checks = 0;
    int errors = 0;
    int gap_max = 0;

    esc_string_decoder #(.MAX_CHARS(MAXC), .ESC_CHAR(8'h5C)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_len(out_len), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_oct(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h37);
    endfunction

    // Reference: parse the escaped text with look-ahead, then apply capacity.
    function automatic void model(input bq_t q, output logic [111:0] d, output int l, output bit e);
        bq_t out;
        int  i = 0;
        int  n = q.size();
        int  v;
        e = 0;
        while (i < n) begin
            if (q[i] != 8'h5C) begin
                out.push_back(q[i]); i += 1;
            end else if (i + 1 >= n) begin
                e = 1; break;
            end else begin
                logic [7:0] c = q[i+1];
                if (c == "n")       begin out.push_back(8'h0A); i += 2; end
                else if (c == "t")  begin out.push_back(8'h09); i += 2; end
                else if (c == 8'h5C) begin out.push_back(8'h5C); i += 2; end
                else if (c == 8'h22) begin out.push_back(8'h22); i += 2; end
                else if (is_oct(c)) begin
                    if (i + 2 >= n) begin e = 1; break; end
                    if (!is_oct(q[i+2])) begin e = 1; i += 3; continue; end
                    if (i + 3 >= n) begin e = 1; break; end
                    if (!is_oct(q[i+3])) begin e = 1; i += 4; continue; end
                    v = 64 * int'(c - 8'h30) + 8 * int'(q[i+2] - 8'h30) + int'(q[i+3] - 8'h30);
                    out.push_back(8'(v % 256));
                    if (v > 255) e = 1;
                    i += 4;
                end else begin
                    out.push_back(c); e = 1; i += 2;
                end
            end
        end
        if (out.size() > MAXC) e = 1;
        d = '0;
        l = (out.size() > MAXC) ? MAXC : out.size();
        for (int k = 0; k < l; k++) d = {d[103:0], out[k]};
    endfunction

    function automatic bq_t to_q(input logic [159:0] b, input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(b[8*(n-1-k) +: 8]);
        return q;
    endfunction

    // Drives one string; returns #1 after the edge that accepted the last byte.
    task automatic send(input bq_t q);
        for (int k = 0; k < q.size(); k++) begin
            int t = 0;
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = q[k];
            in_last  = (k == q.size() - 1);
            while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
            if (t == 50) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [111:0] d, input int l, input bit e);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"},  out_data, d);
        check({tag, "_len"},   out_len, l);
        check({tag, "_err"},   out_err, e);
    endtask

    task automatic drain(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_ready", in_ready, 1);
    endtask

    vec_t vecs[13];

    initial begin
        logic [111:0] md;
        int           ml;
        bit           me;
        bq_t          q;

        vecs[0]  = '{2,  160'h4869,          112'h4869,     2,  1'b0};
        vecs[1]  = '{7,  160'h615C6E5C745C5C, 112'h610A095C, 4,  1'b0};
        vecs[2]  = '{4,  160'h5C313233,      112'h53,       1,  1'b0};
        vecs[3]  = '{4,  160'h5C373737,      112'hFF,       1,  1'b1};
        vecs[4]  = '{2,  160'h5C71,          112'h71,       1,  1'b1};
        vecs[5]  = '{3,  160'h5C3178,        112'h0,        0,  1'b1};
        vecs[6]  = '{15, {15{8'h41}},        {14{8'h41}},   14, 1'b1};
        vecs[7]  = '{1,  160'h5C,            112'h0,        0,  1'b1};
        vecs[8]  = '{2,  160'h5C22,          112'h22,       1,  1'b0};
        vecs[9]  = '{2,  160'h5C31,          112'h0,        0,  1'b1};
        vecs[10] = '{14, {14{8'h41}},        {14{8'h41}},   14, 1'b0};
        vecs[11] = '{5,  160'h415C303030,    112'h4100,     2,  1'b0};
        vecs[12] = '{4,  160'h5C343030,      112'h00,       1,  1'b1};

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data",  out_data, 0);
        check("rst_len",   out_len, 0);
        check("rst_err",   out_err, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        gap_max = 0;
        for (int v = 0; v < 13; v++) begin
            send(to_q(vecs[v].bytes, vecs[v].n));
            expect_out($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].err);
            drain(v % 3);
        end

        // Output held while the sink stalls; a waiting input byte is not taken.
        q = {};
        q.push_back(8'h58);
        send(q);
        in_valid = 1'b1; in_data = 8'h42; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_ready", in_ready, 0);
            expect_out("stall", 112'h58, 1, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_hs_valid", out_valid, 0);
        check("stall_hs_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        expect_out("after_stall", 112'h42, 1, 1'b0);
        drain(0);

        // Reset in the middle of an octal escape discards the partial string.
        in_valid = 1'b1; in_data = 8'h5C; in_last = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_data",  out_data, 0);
        check("midrst_len",   out_len, 0);
        check("midrst_err",   out_err, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        q = {};
        q.push_back(8'h5C); q.push_back(8'h6E);
        send(q);
        expect_out("post_rst", 112'h0A, 1, 1'b0);
        drain(1);

        // Randomized strings against the reference parser.
        gap_max = 2;
        for (int r = 0; r < 200; r++) begin
            int n = $urandom_range(1, 18);
            q = {};
            for (int k = 0; k < n; k++) begin
                int sel = $urandom_range(0, 9);
                logic [7:0] b;
                case (sel)
                    0, 1, 2, 3: b = 8'h41 + 8'($urandom_range(0, 25));
                    4, 5:       b = 8'h5C;
                    6, 7:       b = 8'h30 + 8'($urandom_range(0, 7));
                    8: begin
                        case ($urandom_range(0, 3))
                            0: b = 8'h6E;
                            1: b = 8'h74;
                            2: b = 8'h22;
                            default: b = 8'h38;
                        endcase
                    end
                    default:    b = 8'($urandom_range(0, 255));
                endcase
                q.push_back(b);
            end
            model(q, md, ml, me);
            send(q);
            expect_out($sformatf("rnd%0d", r), md, ml, me);
            drain($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
